tft_framebuffer_scanner: RTL and testbench

//  Pixel source that feeds the ILI9341 frame-buffer driver. It tracks a raster address over a

---
 rtl/tft_framebuffer_scanner_if.sv | 33 +++
 rtl/tft_framebuffer_scanner.sv | 149 ++++++++++++++
 tb/tb_tft_framebuffer_scanner.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tft_framebuffer_scanner_if.sv
// Signal bundle between the raster scanner, the TFT driver and the frame-RAM read port.
// test_mode exists only when TFT_TEST_PATTERN_EN is defined.
interface tft_framebuffer_scanner_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              framebufferClk;
  logic [15:0]       framebufferData;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_rdata;
  logic              frame_sync;
  logic              frame_done;
  logic              overrun;
`ifdef TFT_TEST_PATTERN_EN
  logic              test_mode;
`endif

  modport slave (
    input  framebufferClk, mem_rdata, frame_sync,
`ifdef TFT_TEST_PATTERN_EN
    input  test_mode,
`endif
    output framebufferData, mem_addr, mem_rd, frame_done, overrun
  );

  modport master (
    output framebufferClk, mem_rdata, frame_sync,
`ifdef TFT_TEST_PATTERN_EN
    output test_mode,
`endif
    input  framebufferData, mem_addr, mem_rd, frame_done, overrun
  );
endinterface

// File: rtl/tft_framebuffer_scanner.sv
// Raster pixel fetcher between the frame RAM read port and the ILI9341 driver.
// Define TFT_TEST_PATTERN_EN to add the test_mode colour-bar source.
module tft_framebuffer_scanner #(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tft_framebuffer_scanner_if.slave bus
);
  localparam int unsigned       NPIX     = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_PATTERN} state_e;
  state_e state_q, state_d;

  logic              fbc_q;
  logic              req, issue, pat_sel;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_s, addr_q, addr_d;
  logic              rd_q, rd_d, done_q, done_d;
  logic              pend_q, pend_d, pend_s, ovr_q, ovr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0]       data_q, data_d, pat_data;

  assign req    = bus.framebufferClk & ~fbc_q;
  // frame_sync is folded in before the FSM so a coincident request reads pixel 0
  assign ptr_s  = bus.frame_sync ? '0 : ptr_q;
  assign pend_s = bus.frame_sync ? 1'b0 : pend_q;

`ifdef TFT_TEST_PATTERN_EN
  localparam logic [15:0] BAR [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                      16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [ADDR_W-1:0] col_q, col_d, col_s;
  logic [2:0]        bar_q, bar_d;

  assign pat_sel  = bus.test_mode;
  assign pat_data = BAR[bar_q];
  assign col_s    = bus.frame_sync ? '0 : col_q;

  always_comb begin
    col_d = col_s;
    bar_d = bar_q;
    if (issue) begin
      bar_d = 3'((32'(col_s) * 32'd8) / WIDTH);
      col_d = (32'(col_s) == WIDTH - 1) ? '0 : col_s + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      bar_q <= '0;
    end else begin
      col_q <= col_d;
      bar_q <= bar_d;
    end
  end
`else
  assign pat_sel  = 1'b0;
  assign pat_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_s;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    pend_d  = pend_s;
    ovr_d   = bus.frame_sync ? 1'b0 : ovr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req || pend_s) begin
          issue  = 1'b1;
          pend_d = req && pend_s;
          if (ptr_s == LAST_PIX) begin
            ptr_d  = '0;
            done_d = 1'b1;
          end else begin
            ptr_d = ptr_s + ADDR_W'(1);
          end
          if (pat_sel) begin
            state_d = S_PATTERN;
          end else begin
            addr_d  = ptr_s;
            rd_d    = 1'b1;
            cnt_d   = 3'(MEM_LATENCY);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) state_d = S_CAPTURE;
        cnt_d = cnt_q - 3'd1;
      end
      S_CAPTURE: begin
        data_d  = bus.mem_rdata;
        state_d = S_IDLE;
      end
      S_PATTERN: begin
        data_d  = pat_data;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A request while busy queues once; a second one is dropped and flagged
    if (req && (state_q != S_IDLE)) begin
      if (pend_s) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fbc_q   <= 1'b0;
      ptr_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      fbc_q   <= bus.framebufferClk;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign bus.framebufferData = data_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_rd          = rd_q;
  assign bus.frame_done      = done_q;
  assign bus.overrun         = ovr_q;
endmodule

// File: tb/tb_tft_framebuffer_scanner.sv
// Directed bench for tft_framebuffer_scanner: a full-size 320x240 / latency-1 instance and a
// small 16x4 / latency-4 instance so frame wrap and overrun are reachable in few cycles.
module tb_tft_framebuffer_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  tft_framebuffer_scanner_if #(.ADDR_W(17)) ifa ();
  tft_framebuffer_scanner_if #(.ADDR_W(6))  ifb ();

  tft_framebuffer_scanner #(.WIDTH(320), .HEIGHT(240), .ADDR_W(17), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ifa.slave));
  tft_framebuffer_scanner #(.WIDTH(16), .HEIGHT(4), .ADDR_W(6), .MEM_LATENCY(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ifb.slave));

  // RAM models: data is only valid exactly MEM_LATENCY cycles after mem_rd, 16'hDEAD otherwise
  logic        a_v;
  logic [15:0] a_d;
  always @(posedge clk) begin
    a_v <= ifa.mem_rd;
    a_d <= ifa.mem_addr[15:0];
  end
  assign ifa.mem_rdata = a_v ? a_d : 16'hDEAD;

  logic [3:0]  b_v;
  logic [15:0] b_d [4];
  always @(posedge clk) begin
    b_v    <= {b_v[2:0], ifb.mem_rd};
    b_d[0] <= 16'h1000 | 16'(ifb.mem_addr);
    for (int i = 1; i < 4; i++) b_d[i] <= b_d[i-1];
  end
  assign ifb.mem_rdata = b_v[3] ? b_d[3] : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (ifa.framebufferData !== 16'h0000) begin n_bad++; $display("FAIL rst_data: actual=%h required=0000", ifa.framebufferData); end
    n_cmp++; if (ifa.mem_addr !== 17'd0) begin n_bad++; $display("FAIL rst_addr: actual=%h required=0", ifa.mem_addr); end
    n_cmp++; if (ifa.mem_rd !== 1'b0) begin n_bad++; $display("FAIL rst_rd: actual=%b required=0", ifa.mem_rd); end
    n_cmp++; if (ifa.frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: actual=%b required=0", ifa.frame_done); end
    n_cmp++; if (ifa.overrun !== 1'b0) begin n_bad++; $display("FAIL rst_ovr: actual=%b required=0", ifa.overrun); end
    n_cmp++; if (ifb.framebufferData !== 16'h0000) begin n_bad++; $display("FAIL rst_b_data: actual=%h required=0000", ifb.framebufferData); end
    @(posedge clk); #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick_n(2);
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) begin
      ifa.framebufferClk = 1'b1; tick(); ifa.framebufferClk = 1'b0;
      n_cmp++; if (ifa.mem_rd !== 1'b1) begin n_bad++; $display("FAIL basic_rd k=%0d: actual=%b required=1", k, ifa.mem_rd); end
      n_cmp++; if (ifa.mem_addr !== 17'(k)) begin n_bad++; $display("FAIL basic_addr: actual=%0d required=%0d", ifa.mem_addr, k); end
      tick();
      n_cmp++; if (ifa.mem_rd !== 1'b0) begin n_bad++; $display("FAIL basic_rd_pulse k=%0d: actual=%b required=0", k, ifa.mem_rd); end
      if (k > 0) begin
        n_cmp++; if (ifa.framebufferData !== 16'(k - 1)) begin n_bad++; $display("FAIL basic_hold: actual=%h required=%h", ifa.framebufferData, 16'(k - 1)); end
      end
      tick();
      n_cmp++; if (ifa.framebufferData !== 16'(k)) begin n_bad++; $display("FAIL basic_data: actual=%h required=%h", ifa.framebufferData, 16'(k)); end
    end
  endtask

  task automatic test_sync();
    for (int k = 3; k < 1234; k++) begin
      ifa.framebufferClk = 1'b1; tick(); ifa.framebufferClk = 1'b0;
      n_cmp++; if (ifa.mem_addr !== 17'(k)) begin n_bad++; $display("FAIL seq_addr: actual=%0d required=%0d", ifa.mem_addr, k); end
      tick_n(3);
    end
    ifa.framebufferClk = 1'b1; ifa.frame_sync = 1'b1; tick();
    ifa.framebufferClk = 1'b0; ifa.frame_sync = 1'b0;
    n_cmp++; if (ifa.mem_rd !== 1'b1 || ifa.mem_addr !== 17'd0) begin n_bad++; $display("FAIL sync_addr: actual rd=%b addr=%0d required rd=1 addr=0", ifa.mem_rd, ifa.mem_addr); end
    tick_n(2);
    n_cmp++; if (ifa.framebufferData !== 16'h0000) begin n_bad++; $display("FAIL sync_data: actual=%h required=0000", ifa.framebufferData); end
    ifa.framebufferClk = 1'b1; tick(); ifa.framebufferClk = 1'b0;
    n_cmp++; if (ifa.mem_addr !== 17'd1) begin n_bad++; $display("FAIL sync_next_addr: actual=%0d required=1", ifa.mem_addr); end
    tick_n(2);
    n_cmp++; if (ifa.framebufferData !== 16'h0001) begin n_bad++; $display("FAIL sync_next_data: actual=%h required=0001", ifa.framebufferData); end
    // frame_sync during WAIT: the read at addr 2 still lands
    ifa.framebufferClk = 1'b1; tick(); ifa.framebufferClk = 1'b0;
    ifa.frame_sync = 1'b1; tick(); ifa.frame_sync = 1'b0;
    tick();
    n_cmp++; if (ifa.framebufferData !== 16'h0002) begin n_bad++; $display("FAIL inflight_data: actual=%h required=0002", ifa.framebufferData); end
    ifa.framebufferClk = 1'b1; tick(); ifa.framebufferClk = 1'b0;
    n_cmp++; if (ifa.mem_addr !== 17'd0) begin n_bad++; $display("FAIL inflight_next_addr: actual=%0d required=0", ifa.mem_addr); end
    tick_n(3);
  endtask

  task automatic test_reset_mid();
    ifa.framebufferClk = 1'b1; tick(); ifa.framebufferClk = 1'b0;
    tick_n(3);
    n_cmp++; if (ifa.framebufferData !== 16'h0001) begin n_bad++; $display("FAIL pre_rst_data: actual=%h required=0001", ifa.framebufferData); end
    ifa.framebufferClk = 1'b1; tick(); ifa.framebufferClk = 1'b0;
    #1 rst_a = 1'b0;
    #1;
    n_cmp++; if (ifa.mem_rd !== 1'b0) begin n_bad++; $display("FAIL midrst_rd: actual=%b required=0", ifa.mem_rd); end
    n_cmp++; if (ifa.mem_addr !== 17'd0) begin n_bad++; $display("FAIL midrst_addr: actual=%0d required=0", ifa.mem_addr); end
    n_cmp++; if (ifa.framebufferData !== 16'h0000) begin n_bad++; $display("FAIL midrst_data: actual=%h required=0000", ifa.framebufferData); end
    @(posedge clk); #1 rst_a = 1'b1;
    tick_n(4);
    n_cmp++; if (ifa.framebufferData !== 16'h0000) begin n_bad++; $display("FAIL midrst_hold: actual=%h required=0000", ifa.framebufferData); end
    ifa.framebufferClk = 1'b1; tick(); ifa.framebufferClk = 1'b0;
    n_cmp++; if (ifa.mem_rd !== 1'b1 || ifa.mem_addr !== 17'd0) begin n_bad++; $display("FAIL midrst_next: actual rd=%b addr=%0d required rd=1 addr=0", ifa.mem_rd, ifa.mem_addr); end
    tick_n(3);
  endtask

  task automatic test_overrun();
    logic seen;
    ifb.framebufferClk = 1'b1; tick(); ifb.framebufferClk = 1'b0;
    n_cmp++; if (ifb.mem_rd !== 1'b1 || ifb.mem_addr !== 6'd0) begin n_bad++; $display("FAIL ovr_first: actual rd=%b addr=%0d required rd=1 addr=0", ifb.mem_rd, ifb.mem_addr); end
    tick(); ifb.framebufferClk = 1'b1;
    tick(); ifb.framebufferClk = 1'b0;
    tick(); ifb.framebufferClk = 1'b1;
    tick(); ifb.framebufferClk = 1'b0;
    n_cmp++; if (ifb.overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: actual=%b required=1", ifb.overrun); end
    tick();
    n_cmp++; if (ifb.framebufferData !== 16'h1000) begin n_bad++; $display("FAIL ovr_data0: actual=%h required=1000", ifb.framebufferData); end
    tick();
    n_cmp++; if (ifb.mem_rd !== 1'b1 || ifb.mem_addr !== 6'd1) begin n_bad++; $display("FAIL ovr_pending: actual rd=%b addr=%0d required rd=1 addr=1", ifb.mem_rd, ifb.mem_addr); end
    tick_n(5);
    n_cmp++; if (ifb.framebufferData !== 16'h1001) begin n_bad++; $display("FAIL ovr_data1: actual=%h required=1001", ifb.framebufferData); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); seen |= ifb.mem_rd; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL ovr_dropped: actual rd_seen=%b required=0", seen); end
    ifb.framebufferClk = 1'b1; tick(); ifb.framebufferClk = 1'b0;
    n_cmp++; if (ifb.mem_addr !== 6'd2) begin n_bad++; $display("FAIL ovr_noskip: actual=%0d required=2", ifb.mem_addr); end
    tick_n(6);
    n_cmp++; if (ifb.overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: actual=%b required=1", ifb.overrun); end
    ifb.framebufferClk = 1'b1; ifb.frame_sync = 1'b1; tick();
    ifb.framebufferClk = 1'b0; ifb.frame_sync = 1'b0;
    n_cmp++; if (ifb.overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: actual=%b required=0", ifb.overrun); end
    n_cmp++; if (ifb.mem_addr !== 6'd0) begin n_bad++; $display("FAIL ovr_sync_addr: actual=%0d required=0", ifb.mem_addr); end
    tick_n(6);
  endtask

  task automatic test_frame_wrap();
    int n_done;
    ifb.frame_sync = 1'b1; tick(); ifb.frame_sync = 1'b0;
    n_done = 0;
    for (int i = 0; i < 64; i++) begin
      ifb.framebufferClk = 1'b1; tick(); ifb.framebufferClk = 1'b0;
      n_cmp++; if (ifb.mem_addr !== 6'(i)) begin n_bad++; $display("FAIL wrap_addr: actual=%0d required=%0d", ifb.mem_addr, i); end
      n_cmp++; if (ifb.frame_done !== (i == 63)) begin n_bad++; $display("FAIL wrap_done i=%0d: actual=%b required=%b", i, ifb.frame_done, (i == 63)); end
      if (ifb.frame_done === 1'b1) n_done++;
      for (int j = 0; j < 9; j++) begin tick(); if (ifb.frame_done === 1'b1) n_done++; end
    end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL wrap_done_count: actual=%0d required=1", n_done); end
    ifb.framebufferClk = 1'b1; tick(); ifb.framebufferClk = 1'b0;
    n_cmp++; if (ifb.mem_addr !== 6'd0 || ifb.frame_done !== 1'b0) begin n_bad++; $display("FAIL wrap_next: actual addr=%0d done=%b required addr=0 done=0", ifb.mem_addr, ifb.frame_done); end
    tick_n(6);
  endtask

`ifdef TFT_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [15:0] bar_exp [8];
    logic        seen;
    bar_exp = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    ifa.frame_sync = 1'b1; tick(); ifa.frame_sync = 1'b0;
    ifa.test_mode = 1'b1;
    seen = 1'b0;
    for (int p = 0; p <= 320; p++) begin
      ifa.framebufferClk = 1'b1; tick(); ifa.framebufferClk = 1'b0;
      seen |= ifa.mem_rd;
      tick();
      seen |= ifa.mem_rd;
      if (p % 40 == 0) begin
        n_cmp++; if (ifa.framebufferData !== bar_exp[(p % 320) / 40]) begin n_bad++; $display("FAIL pattern p=%0d: actual=%h required=%h", p, ifa.framebufferData, bar_exp[(p % 320) / 40]); end
      end
      tick(); seen |= ifa.mem_rd;
      tick(); seen |= ifa.mem_rd;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL pattern_no_rd: actual=%b required=0", seen); end
    ifa.test_mode = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.framebufferClk = 1'b0; ifa.frame_sync = 1'b0;
    ifb.framebufferClk = 1'b0; ifb.frame_sync = 1'b0;
`ifdef TFT_TEST_PATTERN_EN
    ifa.test_mode = 1'b0;
    ifb.test_mode = 1'b0;
`endif
    test_reset();
    test_basic();
    test_sync();
    test_reset_mid();
    test_overrun();
    test_frame_wrap();
`ifdef TFT_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
